frame_store_writer: RTL and testbench

Parametrised, single-clock frame writer between the camera-side CDC FIFO and the SDRAM controller write port. It accepts beats over a valid/ready handshake and rotates frames over `NUM_BUFS` frame buffers for multi-exposure HDR capture. Locked buffers are skipped, and a frame is dropped when no buffer is free. Write requests are paced against `ram_busy` through a small pending queue, and completion or abort of each frame is reported.

---
 rtl/frame_store_pkg.sv | 24 ++
 rtl/frame_store_writer_if.sv | 24 ++
 rtl/frame_store_pend_fifo.sv | 51 +++++
 rtl/frame_store_writer.sv | 172 +++++++++++++++++
 tb/tb_frame_store_writer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/frame_store_pkg.sv
// Shared state encoding and elaboration helpers for the frame store writer.
package frame_store_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DROP   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/frame_store_writer_if.sv
// Pixel-beat stream in and RAM write port out, bundled for the frame store writer.
interface frame_store_writer_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 25
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic              ram_busy;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_address;

    modport slave (
        input  in_data, in_valid, in_sof, ram_busy,
        output in_ready, wr_req, wr_data, wr_address
    );

    modport master (
        output in_data, in_valid, in_sof, ram_busy,
        input  in_ready, wr_req, wr_data, wr_address
    );
endinterface

// File: rtl/frame_store_pend_fifo.sv
// Pending-write queue: registered write, combinational head, power-of-two depth.
module frame_store_pend_fifo
    import frame_store_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push, w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/frame_store_writer.sv
// Rotates incoming frames over NUM_BUFS RAM buffers, skipping locked ones,
// and paces writes to the RAM controller through a small pending queue.
module frame_store_writer
    import frame_store_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 25,
    parameter int ADDR_STEP   = 8,
    parameter int FRAME_WORDS = 115200,
    parameter int NUM_BUFS    = 3,
    parameter int PEND_DEPTH  = 4,
    localparam int BUF_W      = idx_w(NUM_BUFS)
) (
    input  logic                clk_133M,
    input  logic                rst_133M,
    frame_store_writer_if.slave bus,
    input  logic [NUM_BUFS-1:0] buf_lock,
    output logic [BUF_W-1:0]    wr_buf,
    output logic                frame_done,
    output logic                frame_err,
    output logic [BUF_W-1:0]    done_buf,
    output logic [7:0]          drop_cnt
);
    localparam int CNT_W = clog2(FRAME_WORDS + 1);
    localparam int FW    = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(FRAME_WORDS * ADDR_STEP);
    localparam longint MAX_ADDR = (longint'(NUM_BUFS) * FRAME_WORDS - 1) * ADDR_STEP;

    if (ADDR_W < 63 && MAX_ADDR >= (64'sd1 <<< ADDR_W)) begin : g_addr_chk
        $error("frame_store_writer: ADDR_W too narrow for NUM_BUFS*FRAME_WORDS*ADDR_STEP");
    end

    state_t            r_state, w_next;
    logic [BUF_W-1:0]  r_wr_buf, r_last_buf, w_sel;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_abort;
    logic [7:0]        r_drop_cnt;
    logic              r_wr_req;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              w_found, w_ready, w_accept, w_sof, w_early_sof, w_last_beat;
    logic              w_push, w_pop, w_full, w_empty, w_flush_done;
    logic [ADDR_W-1:0] w_addr, w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [FW-1:0]     w_head;
    int                w_best, w_dist;

    assign w_sof        = bus.in_valid && bus.in_sof;
    assign w_early_sof  = w_sof && (r_word_cnt != '0);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_last_beat  = (r_word_cnt == CNT_W'(FRAME_WORDS - 1));
    assign w_flush_done = w_empty && !r_wr_req;
    assign w_addr       = ADDR_W'(r_wr_buf) * SPAN + ADDR_W'(r_word_cnt) * ADDR_W'(ADDR_STEP);
    assign {w_head_addr, w_head_data} = w_head;

    // Nearest unlocked buffer after last_buf, in rotation order.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = NUM_BUFS;
        w_dist  = 0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            w_dist = (i - int'(r_last_buf) - 1 + 2 * NUM_BUFS) % NUM_BUFS;
            if (!buf_lock[i] && w_dist < w_best) begin
                w_best  = w_dist;
                w_sel   = BUF_W'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_sof) w_next = ST_SELECT;
            ST_SELECT: w_next = w_found ? ST_WRITE : ST_DROP;
            ST_WRITE:  if (w_early_sof || (w_accept && w_last_beat)) w_next = ST_FLUSH;
            ST_DROP: begin
                if (w_early_sof)                  w_next = ST_SELECT;
                else if (w_accept && w_last_beat) w_next = ST_IDLE;
            end
            ST_FLUSH:  if (w_flush_done) w_next = r_abort ? ST_SELECT : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready    = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = !w_sof;
            ST_WRITE: w_ready = !w_full && !w_early_sof;
            ST_DROP:  w_ready = !w_early_sof;
            ST_FLUSH: begin
                frame_done = w_flush_done && !r_abort;
                frame_err  = w_flush_done && r_abort;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = w_ready && !rst_133M;
    assign w_push       = (r_state == ST_WRITE) && w_accept;

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            r_wr_buf   <= '0;
            r_last_buf <= BUF_W'(NUM_BUFS - 1);
            r_word_cnt <= '0;
            r_abort    <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_SELECT: begin
                    r_word_cnt <= '0;
                    r_abort    <= 1'b0;
                    if (w_found)                r_wr_buf   <= w_sel;
                    else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                end
                ST_WRITE: begin
                    if (w_early_sof)   r_abort    <= 1'b1;
                    else if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
                end
                ST_DROP:  if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
                ST_FLUSH: if (w_flush_done && !r_abort) r_last_buf <= r_wr_buf;
                default: ;
            endcase
        end
    end

    // Back-to-back requests are suppressed so the controller can raise ram_busy.
    assign w_pop = !w_empty && !bus.ram_busy && !r_wr_req;

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            r_wr_req  <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
        end else begin
            r_wr_req <= w_pop;
            if (w_pop) begin
                r_wr_data <= w_head_data;
                r_wr_addr <= w_head_addr;
            end
        end
    end

    frame_store_pend_fifo #(.WIDTH(FW), .DEPTH(PEND_DEPTH)) u_pend (
        .i_clk   (clk_133M),
        .i_rst   (rst_133M),
        .i_push  (w_push),
        .i_wdata ({w_addr, bus.in_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.wr_req     = r_wr_req;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_address = r_wr_addr;
    assign wr_buf         = r_wr_buf;
    assign done_buf       = r_wr_buf;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_frame_store_writer.sv
// Directed scoreboard bench for frame_store_writer (3 buffers, 16-beat frames).
module tb_frame_store_writer;
    localparam int DW = 32, AW = 25, FWORDS = 16, NB = 3;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { bit err; int bufi; } ev_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] buf_lock = '0;
    logic [1:0] wr_buf, done_buf;
    logic frame_done, frame_err;
    logic [7:0] drop_cnt;

    wr_t exp_q[$];
    ev_t ev_q[$];
    int n_assert = 0, n_fail = 0, n_req = 0;
    logic prev_req = 1'b0, prev_busy = 1'b0;

    frame_store_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    frame_store_writer #(
        .DATA_W(DW), .ADDR_W(AW), .ADDR_STEP(8), .FRAME_WORDS(FWORDS),
        .NUM_BUFS(NB), .PEND_DEPTH(4)
    ) dut (
        .clk_133M(clk), .rst_133M(rst), .bus(bus), .buf_lock(buf_lock),
        .wr_buf(wr_buf), .frame_done(frame_done), .frame_err(frame_err),
        .done_buf(done_buf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every request and every frame event is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_req) begin
                n_req++;
                chk("no_b2b_req", {63'd0, prev_req}, 64'd0);
                chk("no_req_when_busy", {63'd0, prev_busy}, 64'd0);
                if (exp_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
                else begin
                    chk("wr_address", 64'(bus.wr_address), 64'(exp_q[0].addr));
                    chk("wr_data", 64'(bus.wr_data), 64'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end
            if (frame_done || frame_err) begin
                chk("writes_drained_at_event", 64'(exp_q.size()), 64'd0);
                if (ev_q.size() == 0) chk("unexpected_event", 64'd1, 64'd0);
                else begin
                    chk("event_is_err", {63'd0, frame_err}, {63'd0, ev_q[0].err});
                    chk("done_buf", 64'(done_buf), 64'(ev_q[0].bufi));
                    void'(ev_q.pop_front());
                end
            end
        end
        prev_req  = bus.wr_req && !rst;
        prev_busy = bus.ram_busy;
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit sof, output bit ok);
        bus.in_data = d; bus.in_sof = sof; bus.in_valid = 1'b1; ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    endtask

    // Beats [from,to) of a frame; wr=0 for a frame expected to be dropped.
    task automatic send_range(input int bufi, input int from, input int to, input bit wr);
        bit ok;
        logic [DW-1:0] d;
        for (int i = from; i < to; i++) begin
            d = $urandom;
            send_beat(d, i == 0, ok);
            if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
            else if (wr) exp_q.push_back('{addr: AW'(bufi * FWORDS * 8 + i * 8), data: d});
        end
    endtask

    task automatic expect_ev(input bit err, input int bufi);
        ev_q.push_back('{err: err, bufi: bufi});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && t < 1000) begin
            @(posedge clk); t++;
        end
        #1;
        chk("drain_timeout", 64'(exp_q.size() + ev_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        chk({tag, "_wr_req"}, {63'd0, bus.wr_req}, 64'd0);
        chk({tag, "_wr_addr"}, 64'(bus.wr_address), 64'd0);
        chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
        chk({tag, "_wr_buf"}, 64'(wr_buf), 64'd0);
        chk({tag, "_done_err"}, {62'd0, frame_done, frame_err}, 64'd0);
        chk({tag, "_done_buf"}, 64'(done_buf), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int req0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.ram_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Three clean frames rotate through buffers 0, 1, 2.
        for (int f = 0; f < 3; f++) begin
            expect_ev(1'b0, f);
            send_range(f, 0, FWORDS, 1'b1);
        end
        wait_drain();

        // ram_busy stalls the queue: four beats fit, then in_ready drops.
        bus.ram_busy = 1'b1;
        expect_ev(1'b0, 0);
        send_range(0, 0, 4, 1'b1);
        chk("busy_ready_low", {63'd0, bus.in_ready}, 64'd0);
        req0 = n_req;
        repeat (16) @(posedge clk);
        #1;
        chk("busy_ready_still_low", {63'd0, bus.in_ready}, 64'd0);
        chk("busy_no_req", 64'(n_req - req0), 64'd0);
        bus.ram_busy = 1'b0;
        send_range(0, 4, FWORDS, 1'b1);
        wait_drain();

        // Buffer 1 locked: rotation skips to buffer 2.
        buf_lock = 3'b010;
        expect_ev(1'b0, 2);
        send_range(2, 0, FWORDS, 1'b1);
        buf_lock = 3'b000;
        wait_drain();
        chk("wr_buf_skip", 64'(wr_buf), 64'd2);

        // All locked: frame is dropped without a single request.
        buf_lock = 3'b111;
        req0 = n_req;
        send_range(0, 0, FWORDS, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        buf_lock = 3'b000;
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
        chk("drop_no_req", 64'(n_req - req0), 64'd0);
        expect_ev(1'b0, 0);
        send_range(0, 0, FWORDS, 1'b1);
        wait_drain();

        // Early sof after 5 beats aborts buffer 1; restart lands on buffer 1 again.
        expect_ev(1'b1, 1);
        send_range(1, 0, 5, 1'b1);
        expect_ev(1'b0, 1);
        send_range(1, 0, FWORDS, 1'b1);
        wait_drain();
        chk("wr_buf_after_abort", 64'(wr_buf), 64'd1);

        // Reset with a full queue discards everything.
        bus.ram_busy = 1'b1;
        send_range(2, 0, 4, 1'b1);
        chk("pre_reset_wr_buf", 64'(wr_buf), 64'd2);
        rst = 1'b1;
        #1 chk_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.ram_busy = 1'b0;
        expect_ev(1'b0, 0);
        send_range(0, 0, FWORDS, 1'b1);
        wait_drain();
        chk("final_drop_cnt", 64'(drop_cnt), 64'd0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
